alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/writeback controller that drives the datapath ALU: it is the producer of `in_a`, `in_b` and `ctrl_aluop`, and the consumer of the ALU's registered `out`.
- Accepts one decoded instruction over a valid/ready handshake, sequences it through the single-cycle registered ALU, and returns a register-file write.
- Latches the zero/negative flags used by BRZ/BRN.
- Sits between the decode stage and the register-file write port.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- REG_AW, 6, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decode offers an instruction
- instr_ready  out  1  controller can accept
- instr_opcode  in  4  instruction opcode
- instr_rd  in  REG_AW  destination register
- rs_data  in  DATA_W  first source value
- rt_data  in  DATA_W  second source value
- alu_in_a  out  DATA_W  to ALU in_a
- alu_in_b  out  DATA_W  to ALU in_b
- ctrl_aluop  out  3  to ALU ctrl_aluop
- alu_out  in  DATA_W  from ALU out (registered in the ALU, 1-cycle latency)
- wb_en  out  1  register-file write strobe, one cycle
- wb_addr  out  REG_AW  write address
- wb_data  out  DATA_W  write data
- flag_z  out  1  last ALU result was zero
- flag_n  out  1  last ALU result bit DATA_W-1
- illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Opcode map (ALU op, operand routing):
  - ADD 0100 → 100, a=rt, b=rs
  - INC 0101 → 010, a=rs
  - NEG 0110 → 001, a=rs
  - SUB 0111 → 000, a=rt, b=rs; the ALU computes b-a, so the result is rs-rt
  - MOV 0010 → 111, a=rs
  - NOP 0000: accepted, no ALU use, no writeback.
  - All other opcodes: illegal.
- Unused operand ports are driven 0.
- FSM states: IDLE, ISSUE, CAPTURE, WB.
- IDLE:
  - instr_ready=1.
  - On valid&ready, latch opcode, rd, rs_data and rt_data.
  - ALU opcode → ISSUE. NOP → IDLE. Illegal → IDLE with illegal=1 for the next cycle.
- ISSUE:
  - Drive alu_in_a, alu_in_b and ctrl_aluop from the latched fields.
  - The ALU registers the result at the end of this cycle.
- CAPTURE:
  - Hold alu_in_a, alu_in_b and ctrl_aluop unchanged, so the ALU's re-evaluation is idempotent and no capture race exists.
  - At the clock edge, register alu_out into the result register, flag_z=(alu_out==0) and flag_n=alu_out[DATA_W-1].
- WB:
  - wb_en=1, wb_addr=latched rd, wb_data=result register.
  - Next state IDLE.
- instr_ready is 0 in ISSUE, CAPTURE and WB. No accept in WB, so there are no back-to-back overlaps.
- Latency: accept edge at cycle T → wb_en high during T+3. Throughput: one ALU instruction per 4 cycles; NOP/illegal take 1 cycle.
- When not in ISSUE or CAPTURE, the ALU port outputs keep their last value. ctrl_aluop resets to 111 (pass) so the ALU never performs an undefined op.
- Arithmetic: modulo 2^DATA_W (ALU wraps). Flags change only in CAPTURE and hold otherwise. NOP and illegal do not touch flags.
- instr_valid deasserted in IDLE: remain IDLE with outputs stable.
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, instr_ready=1 after release
  - alu_in_a=0, alu_in_b=0, ctrl_aluop=111
  - wb_en=0, wb_addr=0, wb_data=0
  - flag_z=0, flag_n=0, illegal=0
- Reset mid-operation aborts the instruction: no wb_en, no flag update.
- illegal and wb_en are mutually exclusive.

Decomposition:
- Shared package holds:
  - opcode constants: OP_NOP, OP_MOV, OP_ADD, OP_INC, OP_NEG, OP_SUB
  - ALU op constants: ALUOP_ADD=100, ALUOP_INC=010, ALUOP_NEG=001, ALUOP_SUB=000, ALUOP_PASS=111
  - FSM state enum
- These constants are shared with the ALU and the decoder.
- One natural sub-module: alu_op_map, a purely combinational mapping of opcode → {aluop, a_sel, b_sel, legal, writes}. The FSM and registers stay in alu_issue_ctrl.

Test Plan:
- Directed scenarios (ALU model attached):
  - Reset then idle → instr_ready=1, wb_en=0, ctrl_aluop=111, flags 0.
  - SUB, rs=10, rt=3, rd=5, accepted cycle T → ctrl_aluop=000, alu_in_a=3, alu_in_b=10 in T+1..T+2; wb_en at T+3 with wb_addr=5, wb_data=7, flag_z=0, flag_n=0.
  - ADD, rs=0xFFFFFFFF, rt=1 → wb_data=0, flag_z=1, flag_n=0. Then NEG with rs=5 → wb_data=0xFFFFFFFB, flag_n=1, flag_z=0.
  - INC, rs=0x7FFFFFFF → wb_data=0x80000000, flag_n=1. Then MOV with rs=0 → wb_data=0, flag_z=1, ctrl_aluop=111.
  - NOP, then opcode 1101 → NOP: ready stays 1, no wb_en, flags unchanged. 1101: illegal pulses exactly one cycle, no wb_en.
  - Back-to-back valid held high for 3 ADDs → accepts exactly every 4th cycle, 3 wb_en pulses. rst_n low during CAPTURE of a 4th op → no wb_en, flags keep their reset values, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared constants for the ALU issue path: instruction opcodes, the ALU's
// ctrl_aluop encodings, operand-select codes used by the opcode map, and the
// issue controller's FSM state type. The decoder and the ALU use the same
// opcode and ALU-op constants, so change them here only.
// ----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    // Instruction opcodes (4 bits)
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MOV = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_INC = 4'b0101;
    localparam logic [3:0] OP_NEG = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;

    // ALU operation codes (3 bits). The ALU's SUB computes in_b - in_a.
    localparam logic [2:0] ALUOP_ADD  = 3'b100;
    localparam logic [2:0] ALUOP_INC  = 3'b010;
    localparam logic [2:0] ALUOP_NEG  = 3'b001;
    localparam logic [2:0] ALUOP_SUB  = 3'b000;
    localparam logic [2:0] ALUOP_PASS = 3'b111;

    // Operand source selects for the ALU input ports
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_RS   = 2'd1;
    localparam logic [1:0] SEL_RT   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WB      = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_alu_op_map.sv
// ----------------------------------------------------------------------------
// alu_op_map
// Purely combinational decode of an instruction opcode into the ALU operation
// and the operand routing for the ALU input ports.
// Ports:
//   i_opcode  in   4  instruction opcode
//   o_aluop   out  3  ALU operation (PASS when the opcode does not use the ALU)
//   o_a_sel   out  2  source for ALU in_a (SEL_ZERO / SEL_RS / SEL_RT)
//   o_b_sel   out  2  source for ALU in_b
//   o_legal   out  1  opcode is supported (NOP included)
//   o_writes  out  1  opcode goes through the ALU and writes the register file
// ----------------------------------------------------------------------------
module alu_op_map
    import alu_issue_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_aluop,
    output logic [1:0] o_a_sel,
    output logic [1:0] o_b_sel,
    output logic       o_legal,
    output logic       o_writes
);

    always_comb begin
        o_aluop  = ALUOP_PASS;
        o_a_sel  = SEL_ZERO;
        o_b_sel  = SEL_ZERO;
        o_legal  = 1'b0;
        o_writes = 1'b0;
        case (i_opcode)
            OP_NOP: begin
                o_legal = 1'b1;
            end
            OP_MOV: begin
                o_aluop = ALUOP_PASS; o_a_sel = SEL_RS;
                o_legal = 1'b1;       o_writes = 1'b1;
            end
            OP_ADD: begin
                o_aluop = ALUOP_ADD;  o_a_sel = SEL_RT; o_b_sel = SEL_RS;
                o_legal = 1'b1;       o_writes = 1'b1;
            end
            OP_INC: begin
                o_aluop = ALUOP_INC;  o_a_sel = SEL_RS;
                o_legal = 1'b1;       o_writes = 1'b1;
            end
            OP_NEG: begin
                o_aluop = ALUOP_NEG;  o_a_sel = SEL_RS;
                o_legal = 1'b1;       o_writes = 1'b1;
            end
            OP_SUB: begin
                // ALU does b - a, so rt goes to a and rs to b to get rs - rt
                o_aluop = ALUOP_SUB;  o_a_sel = SEL_RT; o_b_sel = SEL_RS;
                o_legal = 1'b1;       o_writes = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback controller for the single-cycle registered ALU. Accepts one
// decoded instruction per valid/ready handshake, drives the ALU inputs, captures
// the ALU result one cycle later, latches Z/N flags and emits a one-cycle
// register-file write. NOP completes in the accept cycle; unsupported opcodes
// complete in the accept cycle and pulse `illegal` in the following cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    decode handshake
//   instr_opcode, instr_rd     opcode and destination register
//   rs_data, rt_data           source operand values
//   alu_in_a/alu_in_b/ctrl_aluop  to the ALU (held between instructions)
//   alu_out                    registered ALU result (1-cycle latency)
//   wb_en/wb_addr/wb_data      register-file write port (addr/data 0 when idle)
//   flag_z, flag_n             flags of the last ALU result
//   illegal                    one-cycle unsupported-opcode pulse
// ----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_opcode,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [2:0]        ctrl_aluop,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              illegal
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        w_aluop;
    logic [1:0]        w_a_sel;
    logic [1:0]        w_b_sel;
    logic              w_legal;
    logic              w_writes;
    logic              w_accept;
    logic              w_issue;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_aluop;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_n;
    logic              r_illegal;

    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rs,
        input logic [DATA_W-1:0] rt
    );
        case (sel)
            SEL_RS:  return rs;
            SEL_RT:  return rt;
            default: return '0;
        endcase
    endfunction

    alu_op_map u_op_map (
        .i_opcode (instr_opcode),
        .o_aluop  (w_aluop),
        .o_a_sel  (w_a_sel),
        .o_b_sel  (w_b_sel),
        .o_legal  (w_legal),
        .o_writes (w_writes)
    );

    assign w_accept = instr_valid && instr_ready;
    assign w_issue  = w_accept && w_legal && w_writes;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake/write strobe
    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        wb_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && w_legal && w_writes) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE:   w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_WB;
            ST_WB: begin
                wb_en       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Operands are registered at the accept edge so they are already on the
    // ALU during ISSUE and stay put through CAPTURE and afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_aluop   <= ALUOP_PASS;
            r_result  <= '0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_issue) begin
                r_rd    <= instr_rd;
                r_alu_a <= pick_operand(w_a_sel, rs_data, rt_data);
                r_alu_b <= pick_operand(w_b_sel, rs_data, rt_data);
                r_aluop <= w_aluop;
            end
            if (r_state == ST_CAPTURE) begin
                r_result <= alu_out;
                r_flag_z <= (alu_out == '0);
                r_flag_n <= alu_out[DATA_W-1];
            end
        end
    end

    assign alu_in_a   = r_alu_a;
    assign alu_in_b   = r_alu_b;
    assign ctrl_aluop = r_aluop;
    assign wb_addr    = wb_en ? r_rd : '0;
    assign wb_data    = wb_en ? r_result : '0;
    assign flag_z     = r_flag_z;
    assign flag_n     = r_flag_n;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Drives alu_issue_ctrl with a registered ALU model attached and compares its
// writebacks, flags and pulses against an instruction-level reference model.
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_opcode;
    logic [AW-1:0] instr_rd;
    logic [DW-1:0] rs_data, rt_data;
    logic [DW-1:0] alu_in_a, alu_in_b;
    logic [2:0]    ctrl_aluop;
    logic [DW-1:0] alu_out;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          flag_z, flag_n, illegal;

    int n_pass = 0;
    int n_total = 0;

    // reference flag state, updated only by instructions that write back
    logic m_z = 1'b0;
    logic m_n = 1'b0;

    // observations collected by drive_instr
    logic          obs_acc, obs_rdy1, obs_z, obs_n, obs_zend, obs_nend;
    int            obs_wb_cnt, obs_wb_k, obs_ill_cnt, obs_ill_k;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_data;
    logic [2:0]    obs_op [1:2];
    logic [DW-1:0] obs_a [1:2];
    logic [DW-1:0] obs_b [1:2];

    alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd),
        .rs_data(rs_data), .rt_data(rt_data),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .ctrl_aluop(ctrl_aluop),
        .alu_out(alu_out),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: result appears one cycle after the inputs
    initial alu_out = '0;
    always @(posedge clk) begin
        case (ctrl_aluop)
            3'b100:  alu_out <= alu_in_a + alu_in_b;
            3'b010:  alu_out <= alu_in_a + 32'd1;
            3'b001:  alu_out <= 32'd0 - alu_in_a;
            3'b000:  alu_out <= alu_in_b - alu_in_a;
            3'b111:  alu_out <= alu_in_a;
            default: alu_out <= 32'hDEAD_BEEF;
        endcase
    end

    // Instruction-level model: {illegal, writes, result}
    function automatic logic [DW+1:0] ref_op(input logic [3:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
        case (op)
            4'b0100: return {2'b01, 32'(rs + rt)};
            4'b0101: return {2'b01, 32'(rs + 32'd1)};
            4'b0110: return {2'b01, 32'(32'd0 - rs)};
            4'b0111: return {2'b01, 32'(rs - rt)};
            4'b0010: return {2'b01, rs};
            4'b0000: return {2'b00, 32'd0};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    // Offer one instruction in IDLE, then watch five cycles after the accept edge
    // (k=1 is the cycle right after acceptance). Inputs are scrambled after the
    // accept to make sure the controller works from latched values.
    task automatic drive_instr(input logic [3:0] op, input logic [AW-1:0] rd, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
        @(negedge clk);
        obs_acc = instr_ready;
        instr_valid = 1'b1; instr_opcode = op; instr_rd = rd; rs_data = rs; rt_data = rt;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0; instr_opcode = 4'($urandom); instr_rd = AW'($urandom);
        rs_data = $urandom; rt_data = $urandom;
        obs_wb_cnt = 0; obs_wb_k = 0; obs_ill_cnt = 0; obs_ill_k = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) obs_rdy1 = instr_ready;
            if (k <= 2) begin obs_op[k] = ctrl_aluop; obs_a[k] = alu_in_a; obs_b[k] = alu_in_b; end
            if (wb_en) begin
                obs_wb_cnt++; obs_wb_k = k; obs_addr = wb_addr; obs_data = wb_data;
                obs_z = flag_z; obs_n = flag_n;
            end
            if (illegal) begin obs_ill_cnt++; obs_ill_k = k; end
        end
        obs_zend = flag_z; obs_nend = flag_n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr_opcode = '0; instr_rd = '0; rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        n_total++; if (wb_en !== 1'b0)        $display("FAIL rst_wb_en got %b exp 0", wb_en); else n_pass++;
        n_total++; if (ctrl_aluop !== 3'b111) $display("FAIL rst_aluop got %b exp 111", ctrl_aluop); else n_pass++;
        n_total++; if ({alu_in_a, alu_in_b} !== 64'd0) $display("FAIL rst_alu_in got %h/%h exp 0/0", alu_in_a, alu_in_b); else n_pass++;
        n_total++; if ({wb_addr, wb_data} !== 38'd0) $display("FAIL rst_wb_bus got %h/%h exp 0/0", wb_addr, wb_data); else n_pass++;
        n_total++; if ({flag_z, flag_n, illegal} !== 3'b000) $display("FAIL rst_flags got z%b n%b ill%b exp 000", flag_z, flag_n, illegal); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (instr_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", instr_ready); else n_pass++;
        n_total++; if (wb_en !== 1'b0)       $display("FAIL idle_wb_en got %b exp 0", wb_en); else n_pass++;
        m_z = 1'b0; m_n = 1'b0;
    endtask

    task automatic test_sub();
        drive_instr(4'b0111, 6'd5, 32'd10, 32'd3);
        n_total++; if (obs_acc !== 1'b1) $display("FAIL sub_accept ready got %b exp 1", obs_acc); else n_pass++;
        n_total++; if (obs_rdy1 !== 1'b0) $display("FAIL sub_busy ready got %b exp 0", obs_rdy1); else n_pass++;
        for (int k = 1; k <= 2; k++) begin
            n_total++;
            if (obs_op[k] !== 3'b000 || obs_a[k] !== 32'd3 || obs_b[k] !== 32'd10)
                $display("FAIL sub_alu_ports T+%0d got op%b a=%0d b=%0d exp op000 a=3 b=10", k, obs_op[k], obs_a[k], obs_b[k]);
            else n_pass++;
        end
        n_total++; if (obs_wb_cnt !== 1 || obs_wb_k !== 3) $display("FAIL sub_wb_timing got cnt%0d at T+%0d exp 1 at T+3", obs_wb_cnt, obs_wb_k); else n_pass++;
        n_total++; if (obs_addr !== 6'd5 || obs_data !== 32'd7) $display("FAIL sub_wb got addr%0d data%0d exp 5/7", obs_addr, obs_data); else n_pass++;
        n_total++; if ({obs_z, obs_n} !== 2'b00) $display("FAIL sub_flags got z%b n%b exp 00", obs_z, obs_n); else n_pass++;
        m_z = 1'b0; m_n = 1'b0;
    endtask

    task automatic test_add_neg();
        drive_instr(4'b0100, 6'd9, 32'hFFFF_FFFF, 32'd1);
        n_total++; if (obs_wb_cnt !== 1 || obs_data !== 32'd0) $display("FAIL add_wrap got cnt%0d data%h exp 1/0", obs_wb_cnt, obs_data); else n_pass++;
        n_total++; if ({obs_z, obs_n} !== 2'b10) $display("FAIL add_flags got z%b n%b exp z1 n0", obs_z, obs_n); else n_pass++;
        drive_instr(4'b0110, 6'd10, 32'd5, 32'd77);
        n_total++; if (obs_wb_cnt !== 1 || obs_data !== 32'hFFFF_FFFB) $display("FAIL neg_wb got cnt%0d data%h exp 1/fffffffb", obs_wb_cnt, obs_data); else n_pass++;
        n_total++; if ({obs_z, obs_n} !== 2'b01) $display("FAIL neg_flags got z%b n%b exp z0 n1", obs_z, obs_n); else n_pass++;
        n_total++; if (obs_b[1] !== 32'd0) $display("FAIL neg_unused_b got %h exp 0", obs_b[1]); else n_pass++;
        m_z = 1'b0; m_n = 1'b1;
    endtask

    task automatic test_inc_mov();
        drive_instr(4'b0101, 6'd11, 32'h7FFF_FFFF, 32'h1234);
        n_total++; if (obs_wb_cnt !== 1 || obs_data !== 32'h8000_0000) $display("FAIL inc_wb got cnt%0d data%h exp 1/80000000", obs_wb_cnt, obs_data); else n_pass++;
        n_total++; if ({obs_z, obs_n} !== 2'b01) $display("FAIL inc_flags got z%b n%b exp z0 n1", obs_z, obs_n); else n_pass++;
        drive_instr(4'b0010, 6'd12, 32'd0, 32'hABCD);
        n_total++; if (obs_op[1] !== 3'b111) $display("FAIL mov_aluop got %b exp 111", obs_op[1]); else n_pass++;
        n_total++; if (obs_wb_cnt !== 1 || obs_addr !== 6'd12 || obs_data !== 32'd0) $display("FAIL mov_wb got cnt%0d addr%0d data%h exp 1/12/0", obs_wb_cnt, obs_addr, obs_data); else n_pass++;
        n_total++; if ({obs_z, obs_n} !== 2'b10) $display("FAIL mov_flags got z%b n%b exp z1 n0", obs_z, obs_n); else n_pass++;
        m_z = 1'b1; m_n = 1'b0;
    endtask

    task automatic test_nop_illegal();
        drive_instr(4'b0000, 6'd3, 32'h55, 32'h66);
        n_total++; if (obs_rdy1 !== 1'b1) $display("FAIL nop_ready got %b exp 1", obs_rdy1); else n_pass++;
        n_total++; if (obs_wb_cnt !== 0 || obs_ill_cnt !== 0) $display("FAIL nop_quiet got wb%0d ill%0d exp 0/0", obs_wb_cnt, obs_ill_cnt); else n_pass++;
        n_total++; if ({obs_zend, obs_nend} !== {m_z, m_n}) $display("FAIL nop_flags got z%b n%b exp z%b n%b", obs_zend, obs_nend, m_z, m_n); else n_pass++;
        drive_instr(4'b1101, 6'd4, 32'h0, 32'h0);
        n_total++; if (obs_ill_cnt !== 1 || obs_ill_k !== 1) $display("FAIL ill_pulse got cnt%0d at T+%0d exp 1 at T+1", obs_ill_cnt, obs_ill_k); else n_pass++;
        n_total++; if (obs_wb_cnt !== 0 || obs_rdy1 !== 1'b1) $display("FAIL ill_wb_ready got wb%0d rdy%b exp 0/1", obs_wb_cnt, obs_rdy1); else n_pass++;
        n_total++; if ({obs_zend, obs_nend} !== {m_z, m_n}) $display("FAIL ill_flags got z%b n%b exp z%b n%b", obs_zend, obs_nend, m_z, m_n); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        int n_wb = 0;
        int acc_c [3];
        logic [DW-1:0] exp_d [$];
        logic [AW-1:0] exp_a [$];
        logic [DW-1:0] rs, rt;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wb_en) begin
                n_wb++;
                n_total++;
                if (exp_d.size() == 0) $display("FAIL b2b_extra_wb at cycle %0d data%h", c, wb_data);
                else begin
                    d = exp_d.pop_front(); a = exp_a.pop_front();
                    if (wb_data !== d || wb_addr !== a) $display("FAIL b2b_wb got addr%0d data%h exp %0d/%h", wb_addr, wb_data, a, d);
                    else n_pass++;
                    m_z = (d == 32'd0); m_n = d[DW-1];
                end
            end
            if (instr_ready) begin
                if (n_acc < 3) begin
                    rs = $urandom; rt = $urandom;
                    instr_valid = 1'b1; instr_opcode = 4'b0100; instr_rd = AW'(20 + n_acc);
                    rs_data = rs; rt_data = rt;
                    exp_d.push_back(rs + rt); exp_a.push_back(AW'(20 + n_acc));
                    acc_c[n_acc] = c; n_acc++;
                end else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        n_total++; if (n_acc !== 3 || n_wb !== 3) $display("FAIL b2b_counts got acc%0d wb%0d exp 3/3", n_acc, n_wb); else n_pass++;
        n_total++; if (acc_c[1] - acc_c[0] !== 4 || acc_c[2] - acc_c[1] !== 4) $display("FAIL b2b_spacing got %0d,%0d exp 4,4", acc_c[1] - acc_c[0], acc_c[2] - acc_c[1]); else n_pass++;
        n_total++; if ({flag_z, flag_n} !== {m_z, m_n}) $display("FAIL b2b_flags got z%b n%b exp z%b n%b", flag_z, flag_n, m_z, m_n); else n_pass++;
    endtask

    task automatic test_random();
        logic [DW+1:0] e;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [DW-1:0] rs, rt;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            if (i % 3 == 0) op = 4'($urandom_range(4, 7));
            rd = AW'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            e = ref_op(op, rs, rt);
            drive_instr(op, rd, rs, rt);
            if (e[DW]) begin
                n_total++; if (obs_wb_cnt !== 1 || obs_wb_k !== 3 || obs_ill_cnt !== 0) $display("FAIL rnd_wb_timing op%b got wb%0d at T+%0d ill%0d exp 1 at T+3 ill0", op, obs_wb_cnt, obs_wb_k, obs_ill_cnt); else n_pass++;
                n_total++; if (obs_addr !== rd || obs_data !== e[DW-1:0]) $display("FAIL rnd_wb op%b got addr%0d data%h exp %0d/%h", op, obs_addr, obs_data, rd, e[DW-1:0]); else n_pass++;
                m_z = (e[DW-1:0] == 32'd0); m_n = e[DW-1];
                n_total++; if ({obs_z, obs_n} !== {m_z, m_n}) $display("FAIL rnd_flags op%b got z%b n%b exp z%b n%b", op, obs_z, obs_n, m_z, m_n); else n_pass++;
            end else begin
                n_total++; if (obs_wb_cnt !== 0 || obs_rdy1 !== 1'b1) $display("FAIL rnd_nowb op%b got wb%0d rdy%b exp 0/1", op, obs_wb_cnt, obs_rdy1); else n_pass++;
                n_total++; if (obs_ill_cnt !== int'(e[DW+1]) || (e[DW+1] && obs_ill_k !== 1)) $display("FAIL rnd_illegal op%b got cnt%0d at T+%0d exp %0d", op, obs_ill_cnt, obs_ill_k, e[DW+1]); else n_pass++;
                n_total++; if ({obs_zend, obs_nend} !== {m_z, m_n}) $display("FAIL rnd_flags_hold op%b got z%b n%b exp z%b n%b", op, obs_zend, obs_nend, m_z, m_n); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_wb = 0;
        // result would be 0x80000005 (n=1) if the op were allowed to complete
        @(negedge clk);
        instr_valid = 1'b1; instr_opcode = 4'b0100; instr_rd = 6'd33;
        rs_data = 32'h8000_0000; rt_data = 32'd5;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (wb_en !== 1'b0 || ctrl_aluop !== 3'b111 || alu_in_a !== 32'd0) $display("FAIL midrst_async got wb%b op%b a%h exp 0/111/0", wb_en, ctrl_aluop, alu_in_a); else n_pass++;
        n_total++; if ({flag_z, flag_n} !== 2'b00) $display("FAIL midrst_flags got z%b n%b exp 00", flag_z, flag_n); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_z = 1'b0; m_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (wb_en) n_wb++;
        end
        n_total++; if (n_wb !== 0) $display("FAIL midrst_no_wb got %0d pulses exp 0", n_wb); else n_pass++;
        n_total++; if ({flag_z, flag_n} !== 2'b00) $display("FAIL midrst_flags_after got z%b n%b exp 00", flag_z, flag_n); else n_pass++;
        n_total++; if (instr_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", instr_ready); else n_pass++;
    endtask

    // exclusivity of illegal and wb_en over the whole run
    always @(negedge clk) begin
        if (rst_n && wb_en && illegal) begin
            n_total++;
            $display("FAIL excl_wb_illegal both high at %0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sub();
        test_add_neg();
        test_inc_mov();
        test_nop_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
